line_window_3x3: RTL
====================

# line_window_3x3

Streaming 3x3 neighbourhood generator that sits directly upstream of the convolution datapath. It accepts one 8-bit pixel per cycle in raster order and buffers the two previous image rows. For every interior pixel it presents a complete 3x3 window (w0..w8, row-major, top-left first) so the convolution controller can load it straight into r0..r8. Valid/ready handshakes on both sides provide lossless backpressure.

## Interface

Parameters:
- IMG_W, default 160: pixels per row; 3..256.
- IMG_H, default 120: rows per frame; 3..256.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- pix_in  in  8  input pixel.
- pix_valid  in  1  pix_in is valid this cycle.
- pix_ready  out  1  block can accept a pixel this cycle.
- win_valid  out  1  w0..w8, win_x and win_y hold a valid window.
- win_ready  in  1  downstream consumes the window this cycle.
- w0..w8  out  8 each  window pixels, row-major: w0..w2 top row, w3..w5 middle row, w6..w8 bottom row.
- win_x  out  8  column of the window centre pixel.
- win_y  out  8  row of the window centre pixel.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation

**Handshakes**
- Input accept: `acc = pix_valid && pix_ready`.
- `pix_ready = resetn && (!win_valid || win_ready)`. This is combinational and gives a single output slot with no bubble.

**Counters**
- Input position counters x (0..IMG_W-1) and y (0..IMG_H-1) advance only on acc.
- At x = IMG_W-1, x wraps to 0 and y increments.
- At x = IMG_W-1 and y = IMG_H-1, both wrap to 0 and frame_done pulses.

**Line buffers**
- Two arrays of IMG_W x 8 bits: lb1 holds row y-1, lb2 holds row y-2.
- On acc at column x: the new column is {top = lb2[x], mid = lb1[x], bot = pix_in}. Then lb2[x] <= lb1[x] and lb1[x] <= pix_in.
- Line buffers are not reset. Stale contents are never emitted because of the gating below.

**Column shift register**
- Three columns: L, M, R.
- On acc: L <= M, M <= R, R <= new column.
- It is not cleared at row start. Stale columns have always been shifted out by the time x >= 2.

**Window emission**
- On acc with x >= 2 and y >= 2, load the output registers:
  - w0,w3,w6 = old M (top, mid, bot).
  - w1,w4,w7 = old R.
  - w2,w5,w8 = new column.
  - win_x = x-1, win_y = y-1.
  - Set win_valid.
- Only interior centres are produced, with no padding: (IMG_W-2)*(IMG_H-2) windows per frame, in raster order of the centre.

**Output hold and clear**
- While win_valid && !win_ready, all w*, win_x and win_y hold unchanged.
- win_valid clears on win_ready when there is no simultaneous acc that emits a new window.
- A simultaneous consume and emit replaces the window, and win_valid stays 1.

**Frames**
- Back-to-back frames need no gap. Data is arithmetic-free; pixels pass through unchanged.

## Timing

**Reset**
- Applies on the first rising edge with resetn = 0.
- Reset values: win_valid = 0, frame_done = 0, w0..w8 = 0, win_x = 0, win_y = 0, x = 0, y = 0.
- pix_ready is 0 while resetn = 0.

**Reset mid-frame**
- Discards the partial frame. The next accepted pixel is (0,0).
- No window is emitted until position (2,2) of the new frame.

**Latency**
- One cycle from the acc edge of pixel (x,y) to win_valid for centre (x-1,y-1).

**Throughput**
- One window per cycle when pix_valid and win_ready are held high.

**frame_done**
- High for exactly the one cycle following the acc of pixel (IMG_W-1, IMG_H-1), independent of win_ready.

**Backpressure**
- When win_valid = 1 and win_ready = 0, pix_ready = 0, so no input is lost.
- pix_valid may drop at any time. The counters and buffers then freeze.

## Test plan

Use IMG_W = 4 and IMG_H = 4 for all scenarios. Pixel value = y*4 + x + 16*frame, mod 256.

- **Basic emission.** Stream frame 0 with valid and ready held high. Required: first window one cycle after pixel 10 is accepted, with w0..w8 = 0,1,2,4,5,6,8,9,10 and centre (1,1). Then exactly 3 further windows: centres (2,1) with w4=6, (1,2) with w4=9, (2,2) with w4=10, ending with w8=15.
- **Frame boundary.** Stream frames 0 and 1 back-to-back. Required: frame_done pulses once after pixel 15 and once after pixel 31. Frame 1's first window has w0=16 and w8=26. 8 windows total.
- **Backpressure.** Hold win_ready = 0 for 5 cycles after the first window. Required: pix_ready = 0 throughout, the window stays unchanged (w4=5), and no pixel is dropped. The window sequence is identical to scenario 1.
- **Input gaps.** Apply pix_valid with 50% random gaps. Required: identical window contents and order to scenario 1.
- **Reset mid-frame.** Assert resetn = 0 after pixel 9 is accepted, then restart the frame. Required: win_valid = 0 and all outputs 0 during reset. The first window after reset is again 0,1,2,4,5,6,8,9,10 (values from the restarted frame).

Source files
------------

// File: rtl/line_window_3x3.sv
// line_window_3x3: streaming 3x3 neighbourhood generator for raster-order 8-bit pixels.
// Two line buffers and a column shift register feed one registered window slot with valid/ready.
module line_window_3x3 #(
   parameter int IMG_W = 160,
   parameter int IMG_H = 120
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] pix_in,
   input  logic       pix_valid,
   output logic       pix_ready,
   output logic       win_valid,
   input  logic       win_ready,
   output logic [7:0] w0,
   output logic [7:0] w1,
   output logic [7:0] w2,
   output logic [7:0] w3,
   output logic [7:0] w4,
   output logic [7:0] w5,
   output logic [7:0] w6,
   output logic [7:0] w7,
   output logic [7:0] w8,
   output logic [7:0] win_x,
   output logic [7:0] win_y,
   output logic       frame_done
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
   localparam logic [XW-1:0] X_FIRST_WIN = XW'(2);
   localparam logic [YW-1:0] Y_FIRST_WIN = YW'(2);

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [7:0]    r_lb1 [IMG_W];
   logic [7:0]    r_lb2 [IMG_W];
   logic [23:0]   r_colM;
   logic [23:0]   r_colR;
   logic [7:0]    r_w [9];
   logic [7:0]    r_winX;
   logic [7:0]    r_winY;
   logic          r_winValid;
   logic          r_frameDone;

   logic          w_acc;
   logic          w_emit;
   logic          w_lastX;
   logic          w_lastY;
   logic [23:0]   w_newCol;

   // The output slot frees up in the same cycle it is consumed, so there is no bubble.
   assign pix_ready = resetn && (!r_winValid || win_ready);
   assign w_acc     = pix_valid && pix_ready;
   assign w_lastX   = (r_x == X_LAST);
   assign w_lastY   = (r_y == Y_LAST);
   assign w_emit    = w_acc && (r_x >= X_FIRST_WIN) && (r_y >= Y_FIRST_WIN);
   assign w_newCol  = {r_lb2[r_x], r_lb1[r_x], pix_in};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_acc) begin
         if (w_lastX) begin
            r_x <= '0;
            r_y <= w_lastY ? '0 : r_y + YW'(1);
         end else begin
            r_x <= r_x + XW'(1);
         end
      end
   end

   // Only columns M and R are kept: the leftmost column would never be read.
   // Stale data is flushed by the x >= 2 / y >= 2 gating, so none of this needs a reset.
   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_lb2[r_x] <= r_lb1[r_x];
         r_lb1[r_x] <= pix_in;
         r_colM     <= r_colR;
         r_colR     <= w_newCol;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < 9; i++) begin
            r_w[i] <= '0;
         end
         r_winX      <= '0;
         r_winY      <= '0;
         r_winValid  <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         r_frameDone <= w_acc && w_lastX && w_lastY;
         if (w_emit) begin
            r_w[0]     <= r_colM[23:16];
            r_w[3]     <= r_colM[15:8];
            r_w[6]     <= r_colM[7:0];
            r_w[1]     <= r_colR[23:16];
            r_w[4]     <= r_colR[15:8];
            r_w[7]     <= r_colR[7:0];
            r_w[2]     <= w_newCol[23:16];
            r_w[5]     <= w_newCol[15:8];
            r_w[8]     <= w_newCol[7:0];
            r_winX     <= 8'(r_x) - 8'd1;
            r_winY     <= 8'(r_y) - 8'd1;
            r_winValid <= 1'b1;
         end else if (win_ready) begin
            r_winValid <= 1'b0;
         end
      end
   end

   assign win_valid  = r_winValid;
   assign frame_done = r_frameDone;
   assign win_x      = r_winX;
   assign win_y      = r_winY;
   assign w0         = r_w[0];
   assign w1         = r_w[1];
   assign w2         = r_w[2];
   assign w3         = r_w[3];
   assign w4         = r_w[4];
   assign w5         = r_w[5];
   assign w6         = r_w[6];
   assign w7         = r_w[7];
   assign w8         = r_w[8];

endmodule
